// File: rtl/rs232c_rx_buffer_pkg.sv
// rtl/rs232c_rx_buffer_pkg.sv - shared constants and types for the RS-232C receive buffer
package rs232c_rx_buffer_pkg;

  // 14 ns system clock against a 2000 ns serial bit
  localparam int CLKS_PER_BIT_DEFAULT = 143;
  localparam int DEPTH_LOG2_DEFAULT   = 4;
  localparam int DATA_BITS            = 8;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Width of a down-to-zero-style bit timer able to hold clks-1
  function automatic int timer_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/rs232c_rx_buffer_rx_fifo.sv
// rtl/rs232c_rx_buffer_rx_fifo.sv - receive byte FIFO with overrun flag and simultaneous push/pop
module rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_tvalid,
  input  logic [WIDTH-1:0]      in_tdata,
  output logic                  out_tvalid,
  output logic [WIDTH-1:0]      out_tdata,
  input  logic                  out_tready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int COUNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  wr_en;

  assign empty = (count == '0);
  assign full  = (count == COUNT_W'(DEPTH));
  // A pop on an empty FIFO is simply ignored
  assign pop   = out_tready && !empty;
  // When full, a write only fits if the head is leaving in the same cycle
  assign wr_en = in_tvalid && (!full || pop);

  assign out_tvalid = !empty;
  assign out_tdata  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are meaningless until counted in, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_tdata;
    end
  end

  // Pointers wrap naturally at 2^DEPTH_LOG2; count tracks pushes minus pops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= in_tvalid && !wr_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs232c_rx_buffer.sv
// rtl/rs232c_rx_buffer.sv - RS-232C 8N1 receiver feeding a byte FIFO
module rs232c_rx_buffer
  import rs232c_rx_buffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH_LOG2   = DEPTH_LOG2_DEFAULT
) (
  input  logic                CLK,
  input  logic                XRST,
  input  logic                RS_RX,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic                frame_err,
  output logic                overrun
);

  localparam int TIMER_W = timer_width(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);

  logic                 sync_meta;
  logic                 sync_line;
  logic [1:0]           warm;
  logic                 line_prev;
  logic                 start_edge;
  rx_state_t            state;
  logic [TIMER_W-1:0]   timer;
  logic                 bit_tick;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 push;

  // Two-flop synchronizer; both flops reset to the idle (high) line level
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
    end else begin
      sync_meta <= RS_RX;
      sync_line <= sync_meta;
    end
  end

  // Edge history only trusts the synchronizer once it holds real samples,
  // so a line already low at reset release never looks like a start edge
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      warm      <= 2'd0;
      line_prev <= 1'b0;
    end else begin
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end
      line_prev <= (warm == 2'd2) ? sync_line : 1'b0;
    end
  end

  assign start_edge = line_prev && !sync_line;
  assign bit_tick   = (timer == BIT_LAST);
  // Push straight from the stop-bit sample so the byte is visible next cycle
  assign push       = (state == STOP) && bit_tick && sync_line;

  // Receiver FSM: mid-bit sampling, LSB first, leaves STOP half a bit early
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= 3'd0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer   <= '0;
          bit_idx <= 3'd0;
          if (start_edge) begin
            state <= START;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            state <= sync_line ? IDLE : DATA;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            timer   <= '0;
            shift   <= {sync_line, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            timer <= '0;
            state <= IDLE;
            if (!sync_line) begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk        (CLK),
    .resetn     (XRST),
    .in_tvalid  (push),
    .in_tdata   (shift),
    .out_tvalid (rx_valid),
    .out_tdata  (rx_data),
    .out_tready (rx_ready),
    .count      (rx_count),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_rs232c_rx_buffer.sv
// tb/tb_rs232c_rx_buffer.sv - self-checking bench for rs232c_rx_buffer
module tb_rs232c_rx_buffer;

  localparam int CPB   = 143;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  // Edge count from driving the start bit to the stop-bit sample edge:
  // 2 sync + 1 detect + half bit + 8 bits + 1 bit, in clock cycles
  localparam int PUSH_EDGE = 3 + (CPB / 2) + 8 * CPB + CPB;

  logic           clk = 1'b0;
  logic           xrst = 1'b0;
  logic           rs_rx = 1'b1;
  logic           rx_ready = 1'b0;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [DL2:0]   rx_count;
  logic           frame_err;
  logic           overrun;

  int tests = 0;
  int fails = 0;
  int fe_seen = 0;
  int ovr_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    int         exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t tbl [18];
  logic [7:0] model_q [$];

  rs232c_rx_buffer #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .CLK       (clk),
    .XRST      (xrst),
    .RS_RX     (rs_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #7 clk = ~clk;

  // Count high cycles of each pulse output; a stretched pulse counts twice
  always @(negedge clk) begin
    if (frame_err) fe_seen++;
    if (overrun) ovr_seen++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_cycles);
    @(posedge clk); #1 rs_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rs_rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rs_rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rs_rx = 1'b1;
    repeat (idle_cycles) @(posedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, "_valid"}, rx_valid, 1'b1);
    check({name, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  initial begin
    int g;
    int ov;
    int fe;
    int fe0;
    int ovr0;
    int mfe;
    int movr;

    // Table: 17 good frames 0x00..0x10 with one bad-stop frame inserted
    g = 0; ov = 0; fe = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 5) begin
        tbl[i].data = 8'hEE;
        tbl[i].stop = 1'b0;
        fe++;
      end else begin
        tbl[i].data = 8'(g);
        tbl[i].stop = 1'b1;
        if (g >= DEPTH) ov++;
        g++;
      end
      tbl[i].exp_count = (g > DEPTH) ? DEPTH : g;
      tbl[i].exp_ovr   = ov;
      tbl[i].exp_fe    = fe;
    end

    // Reset state
    repeat (4) @(posedge clk); #1;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_count", rx_count, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    xrst = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Single frame 0x69 and exact push latency
    fork
      send_frame(8'h69, 1'b1, 10);
      begin
        repeat (PUSH_EDGE) @(posedge clk); #1;
        check("valid_before_push", rx_valid, 1'b0);
        @(posedge clk); #1;
        check("valid_after_push", rx_valid, 1'b1);
      end
    join
    check("f69_count", rx_count, 1);
    check("f69_fe", fe_seen, 0);
    pop_expect("f69", 8'h69);
    check("f69_empty_count", rx_count, 0);
    check("f69_empty_data", rx_data, 8'h00);

    // Pop requests on an empty FIFO are ignored
    rx_ready = 1'b1;
    repeat (3) @(posedge clk); #1 rx_ready = 1'b0;
    check("underflow_count", rx_count, 0);
    check("underflow_valid", rx_valid, 1'b0);

    // 500 ns glitch on an idle line
    fe0 = fe_seen;
    @(posedge clk); #1 rs_rx = 1'b0;
    repeat (36) @(posedge clk); #1 rs_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    check("glitch_count", rx_count, 0);
    check("glitch_fe", fe_seen - fe0, 0);

    // Bad stop bit, then a good frame
    fe0 = fe_seen;
    send_frame(8'h55, 1'b0, CPB);
    #1;
    check("badstop_fe", fe_seen - fe0, 1);
    check("badstop_count", rx_count, 0);
    send_frame(8'hA3, 1'b1, 10);
    #1;
    check("a3_count", rx_count, 1);
    pop_expect("a3", 8'hA3);

    // Line held low across reset release is not a start
    fe0 = fe_seen;
    rs_rx = 1'b0;
    xrst = 1'b0;
    repeat (4) @(posedge clk); #1 xrst = 1'b1;
    repeat (300) @(posedge clk); #1 rs_rx = 1'b1;
    repeat (1600) @(posedge clk); #1;
    check("heldlow_count", rx_count, 0);
    check("heldlow_fe", fe_seen - fe0, 0);

    // Reset in the middle of a 0xFF frame, then 0x3C
    fe0 = fe_seen;
    @(posedge clk); #1 rs_rx = 1'b0;
    repeat (CPB) @(posedge clk); #1 rs_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1 xrst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("midreset_count", rx_count, 0);
    xrst = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    send_frame(8'h3C, 1'b1, 10);
    #1;
    check("midreset_after_count", rx_count, 1);
    check("midreset_fe", fe_seen - fe0, 0);
    pop_expect("f3c", 8'h3C);

    // Table-driven fill to overrun
    fe0 = fe_seen;
    ovr0 = ovr_seen;
    for (int i = 0; i < 18; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].stop ? 2 : CPB);
      #1;
      check($sformatf("tbl%0d_count", i), rx_count, tbl[i].exp_count);
      check($sformatf("tbl%0d_ovr", i), ovr_seen - ovr0, tbl[i].exp_ovr);
      check($sformatf("tbl%0d_fe", i), fe_seen - fe0, tbl[i].exp_fe);
    end

    // Push while full with a pop on the same edge
    ovr0 = ovr_seen;
    check("full_head", rx_data, 8'h00);
    fork
      send_frame(8'h11, 1'b1, 10);
      begin
        repeat (PUSH_EDGE) @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
      end
    join
    #1;
    check("fullpp_count", rx_count, DEPTH);
    check("fullpp_ovr", ovr_seen - ovr0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      pop_expect($sformatf("drain%0d", i), 8'(i));
    end
    pop_expect("drain_last", 8'h11);
    check("drained_count", rx_count, 0);

    // Randomized frames and pops against a queue model
    mfe = 0;
    movr = 0;
    fe0 = fe_seen;
    ovr0 = ovr_seen;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       stop;
      int         k;
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, stop, stop ? $urandom_range(0, 40) : CPB);
      #1;
      if (stop) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else movr++;
      end else begin
        mfe++;
      end
      check($sformatf("rnd%0d_count", n), rx_count, model_q.size());
      check($sformatf("rnd%0d_fe", n), fe_seen - fe0, mfe);
      check($sformatf("rnd%0d_ovr", n), ovr_seen - ovr0, movr);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if (model_q.size() > 0) begin
          pop_expect($sformatf("rnd%0d_pop%0d", n, j), model_q[0]);
          void'(model_q.pop_front());
        end else begin
          rx_ready = 1'b1;
          @(posedge clk); #1 rx_ready = 1'b0;
        end
      end
    end
    check("rnd_final_count", rx_count, model_q.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
